// File: rtl/tuner_phy_pkg.sv
// Shared types and constants for the tuner search PHY and its row sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package tuner_phy_pkg;

  // Row sequencer FSM states, exported on the monitor port.
  typedef enum logic [2:0] {
    IDLE,
    SEL,
    TRIG,
    WAIT,
    EVAL,
    NEXT,
    FIN
  } row_seq_state_e;

  // Default per-channel wait for a peak report before giving up on a ring.
  localparam int ROW_SEQ_TIMEOUT_DEFAULT = 4096;

endpackage

// File: rtl/tuner_peak_select.sv
// Picks the highest-power entry among the first cnt peak slots.
// Latency: purely combinational.
// Backpressure: none; the result follows the inputs.
module tuner_peak_select #(
  parameter int NUM_TARGET = 4,
  parameter int DAC_WIDTH  = 8,
  parameter int ADC_WIDTH  = 8,
  localparam int CNT_W     = $clog2(NUM_TARGET + 1)
) (
  input  logic [CNT_W-1:0]                     cnt,
  input  logic [NUM_TARGET-1:0][DAC_WIDTH-1:0] tunes,
  input  logic [NUM_TARGET-1:0][ADC_WIDTH-1:0] powers,
  output logic                                 found,
  output logic [DAC_WIDTH-1:0]                 tune,
  output logic [ADC_WIDTH-1:0]                 power
);

  logic [CNT_W-1:0] eff_cnt;

  // Linear scan; strict greater-than keeps the lowest index on equal power.
  always_comb begin
    eff_cnt = (cnt > CNT_W'(NUM_TARGET)) ? CNT_W'(NUM_TARGET) : cnt;
    found   = 1'b0;
    tune    = '0;
    power   = '0;
    for (int i = 0; i < NUM_TARGET; i++) begin
      if ((CNT_W'(i) < eff_cnt) && (!found || (powers[i] > power))) begin
        found = 1'b1;
        tune  = tunes[i];
        power = powers[i];
      end
    end
  end

endmodule

// File: rtl/tuner_row_search_seq.sv
// Runs one peak search per enabled ring of a row, strictly one channel at a time.
// Latency: per channel 1 SEL + 1 TRIG + N WAIT + 1 EVAL + 1 NEXT, plus 1 FIN cycle per sweep.
// Backpressure: trigger held until trig_rdy; peak report accepted in the cycle it is valid.
module tuner_row_search_seq
  import tuner_phy_pkg::*;
#(
  parameter int NUM_CHANNEL    = 2,
  parameter int NUM_TARGET     = 4,
  parameter int DAC_WIDTH      = 8,
  parameter int ADC_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES = ROW_SEQ_TIMEOUT_DEFAULT,
  localparam int CNT_W         = $clog2(NUM_TARGET + 1),
  localparam int CH_W          = (NUM_CHANNEL > 1) ? $clog2(NUM_CHANNEL) : 1,
  localparam int TO_W          = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1
) (
  input  logic                                                  i_clk,
  input  logic                                                  i_rst,
  input  logic                                                  i_start,
  input  logic [NUM_CHANNEL-1:0]                                i_ch_en,
  output logic                                                  o_busy,
  output logic                                                  o_done,
  output logic [NUM_CHANNEL-1:0]                                o_search_trig_val,
  input  logic [NUM_CHANNEL-1:0]                                i_search_trig_rdy,
  input  logic [NUM_CHANNEL-1:0]                                i_search_peaks_val,
  output logic [NUM_CHANNEL-1:0]                                o_search_peaks_rdy,
  input  logic [NUM_CHANNEL-1:0][CNT_W-1:0]                     i_search_peaks_cnt,
  input  logic [NUM_CHANNEL-1:0][NUM_TARGET-1:0][DAC_WIDTH-1:0] i_search_tune_peaks,
  input  logic [NUM_CHANNEL-1:0][NUM_TARGET-1:0][ADC_WIDTH-1:0] i_search_pwr_peaks,
  output logic [NUM_CHANNEL-1:0][DAC_WIDTH-1:0]                 o_ch_tune,
  output logic [NUM_CHANNEL-1:0][ADC_WIDTH-1:0]                 o_ch_pwr,
  output logic [NUM_CHANNEL-1:0]                                o_ch_found,
  output logic [NUM_CHANNEL-1:0]                                o_ch_timeout,
  output logic [CH_W-1:0]                                       o_mon_ch,
  output row_seq_state_e                                        o_mon_state
);

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CHANNEL - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  row_seq_state_e                       state_q, state_d;
  logic [CH_W-1:0]                      ch_q;
  logic [NUM_CHANNEL-1:0]               mask_q;
  logic [TO_W-1:0]                      to_cnt_q;
  logic [CNT_W-1:0]                     pk_cnt_q;
  logic [NUM_TARGET-1:0][DAC_WIDTH-1:0] pk_tune_q;
  logic [NUM_TARGET-1:0][ADC_WIDTH-1:0] pk_pwr_q;
  logic                                 sel_found;
  logic [DAC_WIDTH-1:0]                 sel_tune;
  logic [ADC_WIDTH-1:0]                 sel_pwr;
  logic                                 last_ch;
  logic                                 expire;

  assign last_ch     = (ch_q == LAST_CH);
  assign expire      = (to_cnt_q == TO_LAST);
  assign o_mon_ch    = ch_q;
  assign o_mon_state = state_q;

  tuner_peak_select #(
    .NUM_TARGET (NUM_TARGET),
    .DAC_WIDTH  (DAC_WIDTH),
    .ADC_WIDTH  (ADC_WIDTH)
  ) u_peak_select (
    .cnt    (pk_cnt_q),
    .tunes  (pk_tune_q),
    .powers (pk_pwr_q),
    .found  (sel_found),
    .tune   (sel_tune),
    .power  (sel_pwr)
  );

  // FSM state register; reset drops any live trigger immediately.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and handshake outputs; only the current channel ever sees trig/rdy.
  always_comb begin
    state_d            = state_q;
    o_busy             = 1'b0;
    o_done             = 1'b0;
    o_search_trig_val  = '0;
    o_search_peaks_rdy = '0;
    case (state_q)
      IDLE: begin
        if (i_start) state_d = (i_ch_en == '0) ? FIN : SEL;
      end
      SEL: begin
        o_busy = 1'b1;
        if (mask_q[ch_q]) state_d = TRIG;
        else if (last_ch) state_d = FIN;
      end
      TRIG: begin
        o_busy                  = 1'b1;
        o_search_trig_val[ch_q] = 1'b1;
        if (i_search_trig_rdy[ch_q]) state_d = WAIT;
      end
      WAIT: begin
        o_busy = 1'b1;
        if (i_search_peaks_val[ch_q]) begin
          o_search_peaks_rdy[ch_q] = 1'b1;
          state_d                  = EVAL;
        end else if (expire) begin
          state_d = NEXT;
        end
      end
      EVAL: begin
        o_busy  = 1'b1;
        state_d = NEXT;
      end
      NEXT: begin
        o_busy  = 1'b1;
        state_d = last_ch ? FIN : SEL;
      end
      FIN: begin
        o_done  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Channel pointer, timeout counter, captured report and published results.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ch_q         <= '0;
      mask_q       <= '0;
      to_cnt_q     <= '0;
      pk_cnt_q     <= '0;
      pk_tune_q    <= '0;
      pk_pwr_q     <= '0;
      o_ch_tune    <= '0;
      o_ch_pwr     <= '0;
      o_ch_found   <= '0;
      o_ch_timeout <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_start) begin
            mask_q <= i_ch_en;
            ch_q   <= '0;
            // Disabled channels keep the results of their last sweep.
            for (int c = 0; c < NUM_CHANNEL; c++) begin
              if (i_ch_en[c]) begin
                o_ch_tune[c]    <= '0;
                o_ch_pwr[c]     <= '0;
                o_ch_found[c]   <= 1'b0;
                o_ch_timeout[c] <= 1'b0;
              end
            end
          end
        end
        SEL: begin
          if (!mask_q[ch_q] && !last_ch) ch_q <= ch_q + CH_W'(1);
        end
        TRIG: begin
          to_cnt_q <= '0;
        end
        WAIT: begin
          to_cnt_q <= to_cnt_q + TO_W'(1);
          // A report arriving on the expiry cycle still counts as found.
          if (i_search_peaks_val[ch_q]) begin
            pk_cnt_q  <= i_search_peaks_cnt[ch_q];
            pk_tune_q <= i_search_tune_peaks[ch_q];
            pk_pwr_q  <= i_search_pwr_peaks[ch_q];
          end else if (expire) begin
            o_ch_timeout[ch_q] <= 1'b1;
            o_ch_found[ch_q]   <= 1'b0;
          end
        end
        EVAL: begin
          o_ch_found[ch_q] <= sel_found;
          o_ch_tune[ch_q]  <= sel_tune;
          o_ch_pwr[ch_q]   <= sel_pwr;
        end
        NEXT: begin
          if (!last_ch) ch_q <= ch_q + CH_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tuner_row_search_seq.sv
// Scoreboard bench for the row search sequencer with two behavioural search PHYs.
// Latency: expected done cycle is pushed with each sweep and checked on o_done.
// Backpressure: PHYs accept triggers at once and hold peaks_val until rdy.
module tb_tuner_row_search_seq;
  import tuner_phy_pkg::*;

  typedef struct {
    int         id;
    logic [15:0] tune;
    logic [15:0] pwr;
    logic [1:0]  found;
    logic [1:0]  tmo;
    int         lat;
    int         tr0;
    int         tr1;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [1:0]           ch_en;
  logic                 busy, done;
  logic [1:0]           trig_val, trig_rdy, peaks_val, peaks_rdy;
  logic                 pv [2];
  logic [1:0][2:0]      ph_cnt;
  logic [1:0][3:0][7:0] ph_tune, ph_pwr;
  int                   ph_delay [2];
  logic [1:0][7:0]      ch_tune, ch_pwr;
  logic [1:0]           ch_found, ch_timeout;
  logic                 mon_ch;
  row_seq_state_e       mon_state;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   viol = 0;
  int   done_cnt = 0;
  int   start_cyc = 0;
  int   trig_cnt [2];
  exp_t sb [$];

  assign peaks_val = {pv[1], pv[0]};

  tuner_row_search_seq #(
    .NUM_CHANNEL(2), .NUM_TARGET(4), .DAC_WIDTH(8), .ADC_WIDTH(8), .TIMEOUT_CYCLES(64)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_ch_en(ch_en),
    .o_busy(busy), .o_done(done),
    .o_search_trig_val(trig_val), .i_search_trig_rdy(trig_rdy),
    .i_search_peaks_val(peaks_val), .o_search_peaks_rdy(peaks_rdy),
    .i_search_peaks_cnt(ph_cnt), .i_search_tune_peaks(ph_tune), .i_search_pwr_peaks(ph_pwr),
    .o_ch_tune(ch_tune), .o_ch_pwr(ch_pwr), .o_ch_found(ch_found), .o_ch_timeout(ch_timeout),
    .o_mon_ch(mon_ch), .o_mon_state(mon_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic exp_t mk(input int id, input logic [7:0] t1, input logic [7:0] t0,
                              input logic [7:0] p1, input logic [7:0] p0,
                              input logic [1:0] f, input logic [1:0] tm,
                              input int lat, input int tr0, input int tr1);
    exp_t e;
    e.id = id; e.tune = {t1, t0}; e.pwr = {p1, p0}; e.found = f; e.tmo = tm;
    e.lat = lat; e.tr0 = tr0; e.tr1 = tr1;
    return e;
  endfunction

  task automatic cfg(input int c, input int dly, input logic [2:0] cnt,
                     input logic [3:0][7:0] tn, input logic [3:0][7:0] pw);
    ph_delay[c] = dly; ph_cnt[c] = cnt; ph_tune[c] = tn; ph_pwr[c] = pw;
  endtask

  // Behavioural PHY: report peaks dly cycles after the trigger handshake (dly<=0: never).
  task automatic phy_serve(input int c);
    forever begin
      do @(negedge clk); while (!(trig_val[c] && trig_rdy[c]));
      if (ph_delay[c] > 0) begin
        repeat (ph_delay[c]) @(posedge clk);
        #1 pv[c] = 1'b1;
        for (int k = 0; k < 8; k++) begin
          @(negedge clk);
          if (peaks_rdy[c]) break;
        end
        @(posedge clk);
        #1 pv[c] = 1'b0;
      end
    end
  endtask

  // Monitor: invariants every cycle, scoreboard compare on each done pulse.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int c = 0; c < 2; c++) begin
          if (trig_val[c] && trig_rdy[c]) trig_cnt[c]++;
          if (peaks_rdy[c] && (!peaks_val[c] || int'(mon_ch) != c)) viol++;
        end
        if ($countones(trig_val) > 1) viol++;
        if (done) begin
          done_cnt++;
          if (sb.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = sb.pop_front();
            chk($sformatf("s%0d_tune", e.id), ch_tune, e.tune);
            chk($sformatf("s%0d_pwr", e.id), ch_pwr, e.pwr);
            chk($sformatf("s%0d_found", e.id), ch_found, e.found);
            chk($sformatf("s%0d_timeout", e.id), ch_timeout, e.tmo);
            chk($sformatf("s%0d_latency", e.id), cyc - start_cyc, e.lat);
            chk($sformatf("s%0d_trigs0", e.id), trig_cnt[0], e.tr0);
            chk($sformatf("s%0d_trigs1", e.id), trig_cnt[1], e.tr1);
          end
        end
      end
    end
  endtask

  task automatic run_sweep(input logic [1:0] mask, input int repulse, input exp_t e);
    int d0;
    bit seen;
    trig_cnt[0] = 0; trig_cnt[1] = 0;
    sb.push_back(e);
    d0 = done_cnt;
    seen = 1'b0;
    @(posedge clk); #1;
    ch_en = mask; start = 1'b1; start_cyc = cyc;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      start = (i == repulse);
      ch_en = (i == repulse) ? 2'b01 : mask;
      if (done_cnt != d0) begin seen = 1'b1; break; end
    end
    start = 1'b0;
    if (!seen) chk($sformatf("s%0d_done_seen", e.id), 0, 1);
    repeat (3) @(posedge clk);
  endtask

  initial begin
    bit reached;
    rst = 1'b1; start = 1'b0; ch_en = 2'b00; trig_rdy = 2'b11;
    pv[0] = 1'b0; pv[1] = 1'b0; trig_cnt[0] = 0; trig_cnt[1] = 0;
    cfg(0, 0, 3'd0, '0, '0);
    cfg(1, 0, 3'd0, '0, '0);
    fork
      monitor();
      phy_serve(0);
      phy_serve(1);
    join_none

    repeat (3) @(negedge clk);
    chk("rst_ctrl", {busy, done, trig_val, peaks_rdy}, 6'd0);
    chk("rst_results", {ch_tune, ch_pwr, ch_found, ch_timeout}, 36'd0);
    chk("rst_mon", {mon_ch, mon_state}, {1'b0, IDLE});
    @(posedge clk); #1 rst = 1'b0;

    // S1: basic two-channel sweep, reports 20 cycles after each trigger.
    cfg(0, 20, 3'd2, {8'd0, 8'd0, 8'd40, 8'd10}, {8'd0, 8'd0, 8'd90, 8'd50});
    cfg(1, 20, 3'd1, {8'd0, 8'd0, 8'd0, 8'd100}, {8'd0, 8'd0, 8'd0, 8'd70});
    run_sweep(2'b11, -1, mk(1, 8'd100, 8'd40, 8'd70, 8'd90, 2'b11, 2'b00, 49, 1, 1));

    // S2: equal powers pick the lower index; ch1 max in the middle.
    cfg(0, 5, 3'd3, {8'd0, 8'd12, 8'd9, 8'd5}, {8'd0, 8'd30, 8'd80, 8'd80});
    cfg(1, 3, 3'd4, {8'd4, 8'd3, 8'd2, 8'd1}, {8'd150, 8'd200, 8'd20, 8'd10});
    run_sweep(2'b11, -1, mk(2, 8'd3, 8'd5, 8'd200, 8'd80, 2'b11, 2'b00, 17, 1, 1));

    // S3: ch0 silent -> timeout after 64 WAIT cycles; ch1 cnt above NUM_TARGET.
    cfg(0, 0, 3'd2, {8'd0, 8'd0, 8'd1, 8'd1}, {8'd0, 8'd0, 8'd1, 8'd1});
    cfg(1, 2, 3'd7, {8'd44, 8'd33, 8'd22, 8'd11}, {8'd40, 8'd30, 8'd20, 8'd60});
    run_sweep(2'b11, -1, mk(3, 8'd11, 8'd0, 8'd60, 8'd0, 2'b10, 2'b01, 74, 1, 1));

    // S4: only ch1 enabled; ch0 keeps its timed-out result.
    cfg(1, 1, 3'd1, {8'd0, 8'd0, 8'd0, 8'd77}, {8'd0, 8'd0, 8'd0, 8'd33});
    run_sweep(2'b10, -1, mk(4, 8'd77, 8'd0, 8'd33, 8'd0, 2'b10, 2'b01, 7, 0, 1));

    // S5: empty mask -> done one cycle after start, nothing touched.
    run_sweep(2'b00, -1, mk(5, 8'd77, 8'd0, 8'd33, 8'd0, 2'b10, 2'b01, 1, 0, 0));

    // S6: ch1 reports zero peaks; start re-pulsed mid-sweep with another mask.
    cfg(0, 4, 3'd2, {8'd0, 8'd0, 8'd60, 8'd50}, {8'd0, 8'd0, 8'd6, 8'd5});
    cfg(1, 6, 3'd0, {8'd7, 8'd7, 8'd7, 8'd7}, {8'd99, 8'd99, 8'd99, 8'd99});
    run_sweep(2'b11, 10, mk(6, 8'd0, 8'd60, 8'd0, 8'd6, 2'b01, 2'b00, 19, 1, 1));

    // S7: reset while waiting on ch1 wipes everything.
    cfg(0, 2, 3'd1, {8'd0, 8'd0, 8'd0, 8'd8}, {8'd0, 8'd0, 8'd0, 8'd9});
    cfg(1, 0, 3'd1, '0, '0);
    @(posedge clk); #1 ch_en = 2'b11; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    reached = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (mon_ch == 1'b1 && mon_state == WAIT) begin reached = 1'b1; break; end
    end
    chk("s7_reach_wait_ch1", reached, 1);
    #2 rst = 1'b1;
    #1;
    chk("s7_rst_ctrl", {busy, done, trig_val, peaks_rdy}, 6'd0);
    chk("s7_rst_state", mon_state, IDLE);
    chk("s7_rst_results", {ch_tune, ch_pwr, ch_found, ch_timeout}, 36'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // S8: fresh sweep after reset completes normally.
    cfg(0, 3, 3'd2, {8'd0, 8'd0, 8'd2, 8'd1}, {8'd0, 8'd0, 8'd41, 8'd40});
    cfg(1, 3, 3'd1, {8'd0, 8'd0, 8'd0, 8'd250}, {8'd0, 8'd0, 8'd0, 8'd200});
    run_sweep(2'b11, -1, mk(8, 8'd250, 8'd2, 8'd200, 8'd41, 2'b11, 2'b00, 15, 1, 1));

    chk("invariants", viol, 0);
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
